// File: rtl/arbitro_rr_pkg.sv
// ============================================================================
//  Module      : arbitro_rr_pkg
//  Description : Shared types and constants for the arbitro_rr round-robin
//                arbiter/router: default parameters, FSM state encoding and
//                the grant-index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arbitro_rr_pkg;

    localparam int DEF_NUM_IN  = 4;
    localparam int DEF_NUM_OUT = 4;
    localparam int DEF_CLASS_W = 2;
    localparam int DEF_DATA_W  = 6;
    localparam int DEF_CNT_W   = 8;

    // ST_IDLE: stage register empty; ST_SERVE: stage register holds an entry
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    // Width of a source index; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arbitro_rr_pick.sv
// ============================================================================
//  Module      : arbitro_rr_pick
//  Description : Combinational rotating-priority encoder. Scans the request
//                vector starting at ptr and wrapping modulo NUM_IN; returns
//                the first requester as a one-hot grant and as an index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_rr_pick
    import arbitro_rr_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int IDX_W  = idx_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_IN-1:0] gnt,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    // Walk the sources in rotated order and keep the first requester found
    always_comb begin
        int pos;
        pos   = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_IN) begin
                pos = pos - NUM_IN;
            end
            if (!valid && req[pos]) begin
                valid    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/arbitro_rr.sv
// ============================================================================
//  Module      : arbitro_rr
//  Description : NUM_IN x NUM_OUT round-robin arbiter/router. Pops at most one
//                eligible source FIFO per cycle and, one cycle later, pushes
//                the entry into the destination chosen by its class, or
//                pulses drop when the class has no destination.
//                Optional feature macro: ARB_CNT_EN adds per-destination push
//                counters on cnt_out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_rr
    import arbitro_rr_pkg::*;
#(
    parameter int NUM_IN  = DEF_NUM_IN,
    parameter int NUM_OUT = DEF_NUM_OUT,
    parameter int CLASS_W = DEF_CLASS_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN-1:0]         FIFO_empty,
    input  logic [NUM_IN*CLASS_W-1:0] class_in,
    input  logic [NUM_IN*DATA_W-1:0]  data_in,
    input  logic [NUM_OUT-1:0]        Almost_full,
    output logic [NUM_IN-1:0]         Pop,
    output logic [NUM_OUT-1:0]        Push,
    output logic [DATA_W-1:0]         data_out,
    output logic                      drop,
    output logic                      idle
`ifdef ARB_CNT_EN
    ,
    output logic [NUM_OUT*CNT_W-1:0]  cnt_out
`endif
);

    localparam int IDX_W = idx_width(NUM_IN);

    // Reject configurations the class decode and counters cannot support
    generate
        if (NUM_IN < 2 || NUM_OUT < 2 || NUM_OUT > (2 ** CLASS_W) || CNT_W < 1) begin : g_param_check
            $error("arbitro_rr: unsupported parameter combination");
        end
    endgenerate

    state_t              r_state;
    logic [IDX_W-1:0]    r_ptr;

    logic [NUM_IN-1:0]   w_req;
    logic [NUM_IN-1:0]   w_gnt;
    logic [IDX_W-1:0]    w_idx;
    logic                w_any;
    logic                w_grant;
    logic [IDX_W-1:0]    w_ptr_next;
    logic [CLASS_W-1:0]  w_g_cls;
    logic [DATA_W-1:0]   w_g_data;
    logic [NUM_OUT-1:0]  w_push_next;
    logic                w_drop_next;

    // A source requests when it has an entry and its destination can take it;
    // classes without a destination are always eligible so they can be dropped
    always_comb begin
        logic [CLASS_W-1:0] cls;
        logic               blk;
        cls   = '0;
        blk   = 1'b0;
        w_req = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            cls = class_in[i*CLASS_W +: CLASS_W];
            blk = 1'b0;
            for (int j = 0; j < NUM_OUT; j++) begin
                if (int'(cls) == j && Almost_full[j]) begin
                    blk = 1'b1;
                end
            end
            w_req[i] = !FIFO_empty[i] && !blk;
        end
    end

    arbitro_rr_pick #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req    (w_req),
        .ptr    (r_ptr),
        .gnt    (w_gnt),
        .idx    (w_idx),
        .valid  (w_any)
    );

    // Reset overrides the grant so no entry leaves a source while reset is high
    assign w_grant    = w_any && !reset;
    assign Pop        = w_grant ? w_gnt : '0;
    assign w_ptr_next = (int'(w_idx) == NUM_IN - 1) ? '0 : w_idx + IDX_W'(1);

    // Select the granted entry and decode where it goes next cycle
    always_comb begin
        w_g_cls     = '0;
        w_g_data    = '0;
        w_push_next = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_gnt[i]) begin
                w_g_cls  = class_in[i*CLASS_W +: CLASS_W];
                w_g_data = data_in[i*DATA_W +: DATA_W];
            end
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            w_push_next[j] = (int'(w_g_cls) == j);
        end
        w_drop_next = (int'(w_g_cls) >= NUM_OUT);
    end

    // Serve FSM: the stage register is the registered Push/data_out/drop set;
    // SERVE means it holds an entry being delivered this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            Push     <= '0;
            data_out <= '0;
            drop     <= 1'b0;
        end else begin
            Push <= '0;
            drop <= 1'b0;
            case (r_state)
                ST_IDLE, ST_SERVE: begin
                    if (w_grant) begin
                        r_state <= ST_SERVE;
                        r_ptr   <= w_ptr_next;
                        if (w_drop_next) begin
                            drop <= 1'b1;
                        end else begin
                            Push     <= w_push_next;
                            data_out <= w_g_data;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign idle = (&FIFO_empty) && (r_state == ST_IDLE);

`ifdef ARB_CNT_EN
    generate
        for (genvar j = 0; j < NUM_OUT; j++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            // Count pushes to destination j, wrapping naturally at full scale
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (Push[j]) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign cnt_out[j*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_arbitro_rr.sv
// ============================================================================
//  Module      : tb_arbitro_rr
//  Description : Self-checking bench for arbitro_rr with NUM_IN=4, NUM_OUT=3
//                (class 3 has no destination and is dropped). Source FIFOs
//                are modelled as queues; the expected grant is the eligible
//                source nearest after the pointer, in modular distance.
//                Honours ARB_CNT_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbitro_rr;

    localparam int NI   = 4;
    localparam int NO   = 3;
    localparam int CW   = 2;
    localparam int DW   = 6;
    localparam int CNTW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NI-1:0]     FIFO_empty;
    logic [NI*CW-1:0]  class_in;
    logic [NI*DW-1:0]  data_in;
    logic [NO-1:0]     Almost_full;
    logic [NI-1:0]     Pop;
    logic [NO-1:0]     Push;
    logic [DW-1:0]     data_out;
    logic              drop;
    logic              idle;
`ifdef ARB_CNT_EN
    logic [NO*CNTW-1:0] cnt_out;
`endif

    arbitro_rr #(
        .NUM_IN      (NI),
        .NUM_OUT     (NO),
        .CLASS_W     (CW),
        .DATA_W      (DW),
        .CNT_W       (CNTW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .FIFO_empty  (FIFO_empty),
        .class_in    (class_in),
        .data_in     (data_in),
        .Almost_full (Almost_full),
        .Pop         (Pop),
        .Push        (Push),
        .data_out    (data_out),
        .drop        (drop),
        .idle        (idle)
`ifdef ARB_CNT_EN
        ,
        .cnt_out     (cnt_out)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: each entry is {class[1:0], data[5:0]}
    logic [7:0]    srcq [NI][$];
    int            m_ptr = 0;
    bit            m_pv = 0;
    int            m_pcls = 0;
    logic [DW-1:0] m_pdata = '0;
    logic [DW-1:0] m_last = '0;
    int            m_cnt [NO];
    logic [NO-1:0] af_val = '0;
    logic [NI-1:0] last_pop = '0;
    bit            rand_fill = 0;

    task automatic drive_inputs();
        logic [7:0] h;
        for (int i = 0; i < NI; i++) begin
            if (srcq[i].size() > 0) begin
                h = srcq[i][0];
                FIFO_empty[i] = 1'b0;
                class_in[i*CW +: CW] = h[7:6];
                data_in[i*DW +: DW]  = h[5:0];
            end else begin
                FIFO_empty[i] = 1'b1;
                class_in[i*CW +: CW] = CW'($urandom);
                data_in[i*DW +: DW]  = DW'($urandom);
            end
        end
        Almost_full = af_val;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NI; i++) begin
            if (srcq[i].size() != 0) return 0;
        end
        return 1;
    endfunction

    // One clock cycle: drive at the falling edge, check shortly after, then
    // advance the model to what the next rising edge should produce
    task automatic step(input bit rst_now);
        logic [NO-1:0] exp_push;
        logic          exp_drop;
        logic [NI-1:0] exp_pop;
        logic [7:0]    h;
        int            best;
        int            bestd;
        int            d;
        int            cls;
        @(negedge clk);
        if (rand_fill) begin
            for (int i = 0; i < NI; i++) begin
                if (srcq[i].size() < 4 && $urandom_range(0, 99) < 45) begin
                    srcq[i].push_back(8'($urandom));
                end
            end
        end
        reset = rst_now;
        drive_inputs();
        #1;
        if (rst_now) begin
            m_ptr  = 0;
            m_pv   = 0;
            m_last = '0;
            for (int j = 0; j < NO; j++) m_cnt[j] = 0;
        end
        exp_push = '0;
        exp_drop = 1'b0;
        if (m_pv) begin
            if (m_pcls < NO) begin
                exp_push[m_pcls] = 1'b1;
                m_last = m_pdata;
            end else begin
                exp_drop = 1'b1;
            end
        end
        check("push", 32'(Push), 32'(exp_push));
        check("drop", 32'(drop), 32'(exp_drop));
        check("data_out", 32'(data_out), 32'(m_last));
        check("idle", 32'(idle), 32'(all_empty() && !m_pv));
`ifdef ARB_CNT_EN
        for (int j = 0; j < NO; j++) begin
            check("cnt", 32'(cnt_out[j*CNTW +: CNTW]), 32'(m_cnt[j]));
            if (exp_push[j]) m_cnt[j] = (m_cnt[j] + 1) % (1 << CNTW);
        end
`endif
        best  = -1;
        bestd = NI;
        if (!rst_now) begin
            for (int i = 0; i < NI; i++) begin
                if (srcq[i].size() > 0) begin
                    h   = srcq[i][0];
                    cls = int'(h[7:6]);
                    d   = (i - m_ptr + NI) % NI;
                    if ((cls >= NO || !af_val[cls]) && d < bestd) begin
                        best  = i;
                        bestd = d;
                    end
                end
            end
        end
        exp_pop = '0;
        if (best >= 0) exp_pop[best] = 1'b1;
        check("pop", 32'(Pop), 32'(exp_pop));
        last_pop = Pop;
        if (best >= 0) begin
            h       = srcq[best].pop_front();
            m_pv    = 1;
            m_pcls  = int'(h[7:6]);
            m_pdata = h[5:0];
            m_ptr   = (best + 1) % NI;
        end else begin
            m_pv = 0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        af_val = '0;
        while ((!all_empty() || m_pv) && n < 200) begin
            step(0);
            n++;
        end
        check("drain_timeout", 32'(!all_empty() || m_pv), 32'd0);
        step(0);
    endtask

    logic [NI-1:0] rr_seq [5];

    initial begin
        rr_seq[0] = 4'b0001;
        rr_seq[1] = 4'b0010;
        rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000;
        rr_seq[4] = 4'b0001;
        for (int j = 0; j < NO; j++) m_cnt[j] = 0;
        reset = 1'b1;
        drive_inputs();

        // Reset and an empty system: nothing moves, idle stays high
        step(1);
        step(1);
        for (int k = 0; k < 10; k++) step(0);

        // Every source loaded with its own class: plain rotation
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 2; k++) srcq[i].push_back({2'(i), 6'(i * 4 + k)});
        end
        for (int k = 0; k < 5; k++) begin
            step(0);
            check("rr_seq", 32'(last_pop), 32'(rr_seq[k]));
        end
        drain();

        // Destination 2 almost full: source 1 (class 2) must be skipped
        for (int k = 0; k < 2; k++) srcq[1].push_back({2'd2, 6'(16 + k)});
        for (int i = 0; i < NI; i++) begin
            if (i != 1) begin
                for (int k = 0; k < 3; k++) srcq[i].push_back({2'd0, 6'(32 + i * 4 + k)});
            end
        end
        af_val = 3'b100;
        for (int k = 0; k < 3; k++) begin
            step(0);
            check("af_skip", 32'(last_pop[1]), 32'd0);
        end
        af_val = '0;
        for (int k = 0; k < 4; k++) step(0);
        drain();

        // Lone entry whose class has no destination is popped then dropped
        srcq[0].push_back({2'd3, 6'h2A});
        step(0);
        check("drop_pop", 32'(last_pop), 32'b0001);
        step(0);
        check("drop_pulse", 32'(drop), 32'd1);
        check("drop_nopush", 32'(Push), 32'd0);
        drain();

        // Reset in the cycle after a grant: entry discarded, pointer back to 0
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 3; k++) srcq[i].push_back({2'(k % 3), 6'(48 + i * 3 + k)});
        end
        step(0);
        step(0);
        step(1);
        check("rst_push", 32'(Push), 32'd0);
        check("rst_pop", 32'(Pop), 32'd0);
        step(0);
        check("rst_first", 32'(last_pop), 32'b0001);
        drain();

        // Random traffic with random back-pressure
        rand_fill = 1;
        for (int k = 0; k < 1500; k++) begin
            af_val = NO'($urandom);
            if ($urandom_range(0, 3) == 0) af_val = '0;
            step(0);
        end
        rand_fill = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/arbitro_rr.md
# arbitro_rr

Parametrised round-robin arbiter/router between a bank of NUM_IN source FIFOs and NUM_OUT destination FIFOs. Each cycle it selects at most one non-empty source whose head-of-line entry is headed to a destination that is not almost full, pops it, and pushes the entry one cycle later into the destination selected by the entry's class. It generalises the single-source, four-destination class router to N×M with fairness, a data path and drop handling.

## Interface
- NUM_IN, default 4: number of source FIFOs (≥2).
- NUM_OUT, default 4: number of destination FIFOs (≥2, ≤2^CLASS_W).
- CLASS_W, default 2: width of one class field.
- DATA_W, default 6: width of one FIFO entry.
- CNT_W, default 8: width of each push counter (used only under ARB_CNT_EN).
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- FIFO_empty  input  NUM_IN  bit i high: source i empty.
- class_in  input  NUM_IN*CLASS_W  head-of-line class of source i in slice i; valid only when FIFO_empty[i]=0.
- data_in  input  NUM_IN*DATA_W  head-of-line data of source i (first-word-fall-through).
- Almost_full  input  NUM_OUT  bit j high: destination j cannot accept a new push.
- Pop  output  NUM_IN  one-hot or zero; pop of granted source, same cycle.
- Push  output  NUM_OUT  one-hot or zero; registered push to destination.
- data_out  output  DATA_W  registered data accompanying Push.
- drop  output  1  registered one-cycle pulse: popped entry had class ≥ NUM_OUT and was discarded.
- idle  output  1  high when all sources empty and no push/drop in flight.
- cnt_out  output  NUM_OUT*CNT_W  per-destination push counts (ARB_CNT_EN only).

## Operation
- Eligibility of source i: FIFO_empty[i]=0 AND (class_i ≥ NUM_OUT OR Almost_full[class_i]=0).
- Grant: first eligible source scanning i = ptr, ptr+1, … modulo NUM_IN; ptr is a registered pointer.
- Pop[grant] asserted combinationally in the cycle of the grant; no Pop if no source eligible or reset high.
- On grant: ptr ← (grant+1) mod NUM_IN; no grant leaves ptr unchanged.
- Stage register: captures valid, class and data of the granted entry.
- Cycle after a grant: if class < NUM_OUT → Push[class]=1, data_out=data; else drop=1, Push=0.
- FSM (2 states): IDLE (no entry in stage register) and SERVE (stage register valid). IDLE→SERVE on a grant; SERVE→SERVE on a further grant (back-to-back, one entry per cycle); SERVE→IDLE when no grant.
- Almost_full is sampled in the grant cycle only; destinations must assert it with ≥1 free slot margin to absorb the in-flight push.
- data_out holds its last value when Push=0.

## Timing
- Reset values: Pop=0, Push=0, data_out=0, drop=0, idle=1, ptr=0, FSM=IDLE, cnt_out=0.
- Latency Pop→Push/drop: exactly 1 cycle. Throughput: 1 entry/cycle.
- Reset asserted mid-operation: stage entry discarded (no Push), ptr and counters cleared immediately; Pop forced 0 while reset high.
- All sources empty or all blocked: Pop=0; following cycle Push=0.
- Almost_full rising in the same cycle as a grant to that destination: grant is suppressed.
- Single eligible source: granted every cycle it is eligible regardless of ptr.

## Configuration
- ARB_CNT_EN defined: cnt_out present; counter j increments on each Push[j], wraps from 2^CNT_W−1 to 0; cleared by reset.
- ARB_CNT_EN undefined: cnt_out port and counters absent; all other behaviour identical.

## Structure
- Shared package: grant index width (clog2 NUM_IN), FSM state encoding (ST_IDLE, ST_SERVE), default parameter constants.
- One sub-module: arbitro_rr_pick — combinational rotating-priority encoder (request vector + ptr → one-hot grant + index).

## Test plan
- Reset, all FIFO_empty=1 → Pop=0, Push=0, idle=1 for 10 cycles.
- NUM_IN=4, all sources non-empty, classes 0,1,2,3, Almost_full=0 → Pop sequence 0001,0010,0100,1000,0001; Push one cycle later 0001,0010,0100,1000 with matching data_out.
- Source 1 class 2, Almost_full=0100 for 3 cycles → source 1 skipped those cycles, others served; after release source 1 granted on its next round-robin turn.
- Source 0 head class 3 with NUM_OUT=3 → Pop[0]=1, next cycle drop=1, Push=0.
- Reset asserted in the cycle after a grant → no Push, ptr=0, next grant from source 0.
- ARB_CNT_EN, CNT_W=2, five pushes to destination 0 → cnt_out slice 0 reads 1.
